// File: rtl/adc_sync_lock_ctrl_if.sv
// Signal bundle between the ADC SYNC/lock controller and its user.
// The slave side is the controller; the master side drives requests and the ADR toggle.
interface adc_sync_lock_ctrl_if;
  logic       sync_req;
  logic       dr_toggle;
  logic       sync_o;
  logic       busy;
  logic       locked;
  logic       fail;
  logic [1:0] retry_cnt;
  logic [2:0] state_o;

  modport master (
    output sync_req, dr_toggle,
    input  sync_o, busy, locked, fail, retry_cnt, state_o
  );

  modport slave (
    input  sync_req, dr_toggle,
    output sync_o, busy, locked, fail, retry_cnt, state_o
  );
endinterface

// File: rtl/adc_sync_lock_ctrl.sv
// Issues SYNC to the ADC and waits for the divided data-ready toggle to restart and run steadily.
// Re-issues SYNC on timeout or loss of the toggle, and gives up after MAX_RETRY attempts.
module adc_sync_lock_ctrl #(
  parameter int SYNC_WIDTH = 16,
  parameter int TIMEOUT    = 4096,
  parameter int GAP_MAX    = 64,
  parameter int LOCK_EDGES = 256,
  parameter int MAX_RETRY  = 3,
  parameter bit AUTO_START = 1'b1
) (
  input  logic                gclk10m_buf,
  input  logic                sys_rst_n,
  adc_sync_lock_ctrl_if.slave bus
);

  localparam int SCW = (SYNC_WIDTH > 1) ? $clog2(SYNC_WIDTH) : 1;
  localparam int TW  = (TIMEOUT    > 1) ? $clog2(TIMEOUT)    : 1;
  localparam int GW  = (GAP_MAX    > 1) ? $clog2(GAP_MAX)    : 1;
  localparam int EW  = (LOCK_EDGES > 1) ? $clog2(LOCK_EDGES) : 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SYNC    = 3'd1,
    ST_WAIT_DR = 3'd2,
    ST_COUNT   = 3'd3,
    ST_LOCKED  = 3'd4,
    ST_FAIL    = 3'd5
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic           w_retry;
  logic           w_drEdge;
  logic           r_drMeta;
  logic           r_drSync;
  logic           r_drHist;
  logic           r_started;
  logic           r_syncO;
  logic           r_busy;
  logic           r_locked;
  logic           r_fail;
  logic [1:0]     r_retryCnt;
  logic [SCW-1:0] r_syncCnt;
  logic [TW-1:0]  r_timer;
  logic [GW-1:0]  r_gap;
  logic [EW-1:0]  r_edgeCnt;

  // Either polarity of the toggle counts as one edge once it is safely in our domain.
  always_ff @(posedge gclk10m_buf or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_drMeta <= 1'b0;
      r_drSync <= 1'b0;
      r_drHist <= 1'b0;
    end else begin
      r_drMeta <= bus.dr_toggle;
      r_drSync <= r_drMeta;
      r_drHist <= r_drSync;
    end
  end

  assign w_drEdge = r_drSync ^ r_drHist;

  always_comb begin
    w_next  = r_state;
    w_retry = 1'b0;
    case (r_state)
      ST_IDLE:    if (bus.sync_req || (AUTO_START && !r_started)) w_next = ST_SYNC;
      ST_SYNC:    if (r_syncCnt == SCW'(SYNC_WIDTH - 1)) w_next = ST_WAIT_DR;
      ST_WAIT_DR: begin
        if (w_drEdge)                          w_next  = ST_COUNT;
        else if (r_timer == TW'(TIMEOUT - 1))  w_retry = 1'b1;
      end
      ST_COUNT: begin
        if (w_drEdge) begin
          if (r_edgeCnt == EW'(LOCK_EDGES - 1)) w_next = ST_LOCKED;
        end else if (r_gap == GW'(GAP_MAX - 1)) begin
          w_retry = 1'b1;
        end
      end
      ST_LOCKED: begin
        if (bus.sync_req)                                   w_next  = ST_SYNC;
        else if (!w_drEdge && (r_gap == GW'(GAP_MAX - 1)))  w_retry = 1'b1;
      end
      ST_FAIL:    if (bus.sync_req) w_next = ST_SYNC;
      default:    w_next = ST_IDLE;
    endcase
    if (w_retry) w_next = (r_retryCnt < 2'(MAX_RETRY)) ? ST_SYNC : ST_FAIL;
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge gclk10m_buf or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_started  <= 1'b0;
      r_syncO    <= 1'b0;
      r_busy     <= 1'b0;
      r_locked   <= 1'b0;
      r_fail     <= 1'b0;
      r_retryCnt <= '0;
      r_syncCnt  <= '0;
      r_timer    <= '0;
      r_gap      <= '0;
      r_edgeCnt  <= '0;
    end else begin
      r_state   <= w_next;
      r_started <= 1'b1;
      r_syncO   <= (w_next == ST_SYNC);
      r_busy    <= (w_next == ST_SYNC) || (w_next == ST_WAIT_DR) || (w_next == ST_COUNT);
      r_locked  <= (w_next == ST_LOCKED);
      r_fail    <= (w_next == ST_FAIL);

      // Automatic retries count up; any other entry into SYNC starts a fresh sequence.
      if (w_retry && (w_next == ST_SYNC))
        r_retryCnt <= r_retryCnt + 1'b1;
      else if ((w_next == ST_SYNC) && (r_state != ST_SYNC))
        r_retryCnt <= '0;

      r_syncCnt <= ((r_state == ST_SYNC) && (w_next == ST_SYNC)) ? r_syncCnt + 1'b1 : '0;
      r_timer   <= ((r_state == ST_WAIT_DR) && (w_next == ST_WAIT_DR)) ? r_timer + 1'b1 : '0;

      if (w_next == ST_COUNT)
        r_edgeCnt <= (r_state == ST_COUNT) ? r_edgeCnt + EW'(w_drEdge) : EW'(1);
      else
        r_edgeCnt <= '0;

      if (((w_next == ST_COUNT) || (w_next == ST_LOCKED)) &&
          ((r_state == ST_COUNT) || (r_state == ST_LOCKED)) && !w_drEdge)
        r_gap <= r_gap + 1'b1;
      else
        r_gap <= '0;
    end
  end

  assign bus.sync_o    = r_syncO;
  assign bus.busy      = r_busy;
  assign bus.locked    = r_locked;
  assign bus.fail      = r_fail;
  assign bus.retry_cnt = r_retryCnt;
  assign bus.state_o   = r_state;

endmodule

// File: tb/tb_adc_sync_lock_ctrl.sv
// Self-checking bench for adc_sync_lock_ctrl: random toggle periods against a timestamp-based model
// of the SYNC/lock sequence, plus directed checks on pulse spacing, retries and reset behaviour.
module tb_adc_sync_lock_ctrl;
  localparam int SW = 16;
  localparam int TO = 4096;
  localparam int GM = 64;
  localparam int LE = 256;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic sysRstN;
  always #5 clk = ~clk;

  adc_sync_lock_ctrl_if bus ();
  adc_sync_lock_ctrl_if bus2 ();

  adc_sync_lock_ctrl #(.AUTO_START(1'b1)) u_dut (
    .gclk10m_buf(clk), .sys_rst_n(sysRstN), .bus(bus)
  );
  adc_sync_lock_ctrl #(.AUTO_START(1'b0)) u_dut2 (
    .gclk10m_buf(clk), .sys_rst_n(sysRstN), .bus(bus2)
  );

  int   testsRun = 0;
  int   testsFailed = 0;
  int   cyc = 0;
  logic drPin = 1'b0;
  logic prevSync = 1'b0;
  int   riseCyc[$];

  // Model: state code, sequence timestamps (absolute cycle numbers) and the pin history.
  int mState, mRetry, mEnter, mLastEdge, mEdges;
  bit mAuto;
  bit h1, h2, h3;

  task automatic modelReset(input bit autoStart);
    mState = 0; mRetry = 0; mEnter = 0; mLastEdge = 0; mEdges = 0;
    mAuto = autoStart; h1 = 0; h2 = 0; h3 = 0;
  endtask

  task automatic modelStartSync(input int c, input bit fresh);
    mState = 1;
    mEnter = c;
    if (fresh) mRetry = 0;
  endtask

  task automatic modelStep(input bit req, input bit pin, input int c);
    bit e;
    bit lost;
    e    = h2 ^ h3;
    lost = 0;
    case (mState)
      0: if (req || mAuto) modelStartSync(c, 1);
      1: if (c - mEnter == SW) begin mState = 2; mEnter = c; end
      2: begin
        if (e) begin mState = 3; mEdges = 1; mLastEdge = c; end
        else if (c - mEnter == TO) lost = 1;
      end
      3: begin
        if (e) begin
          mEdges++;
          mLastEdge = c;
          if (mEdges == LE) mState = 4;
        end else if (c - mLastEdge == GM) lost = 1;
      end
      4: begin
        if (req) modelStartSync(c, 1);
        else if (e) mLastEdge = c;
        else if (c - mLastEdge == GM) lost = 1;
      end
      default: if (req) modelStartSync(c, 1);
    endcase
    if (lost) begin
      if (mRetry < MR) begin mRetry++; modelStartSync(c, 0); end
      else mState = 5;
    end
    mAuto = 0;
    h3 = h2; h2 = h1; h1 = pin;
  endtask

  task automatic noteFail();
    if (testsFailed >= 40) begin
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $fatal(1, "[TB] too many errors, stopping");
    end
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      noteFail();
    end
  endtask

  task automatic checkOutput();
    logic [9:0] expVec;
    logic [9:0] obsVec;
    expVec = {3'(mState), (mState == 1), (mState >= 1 && mState <= 3), (mState == 4),
              (mState == 5), 2'(mRetry)};
    obsVec = {bus.state_o, bus.sync_o, bus.busy, bus.locked, bus.fail, bus.retry_cnt};
    testsRun++;
    assert (obsVec === expVec) else begin
      testsFailed++;
      $error("[TB] FAIL cycle%0d {state,sync,busy,locked,fail,retry}: observed %b expected %b",
             cyc, obsVec, expVec);
      noteFail();
    end
    if (bus.sync_o === 1'b1 && prevSync === 1'b0) riseCyc.push_back(cyc);
    prevSync = bus.sync_o;
  endtask

  task automatic applyStimulus(input logic req);
    bus.sync_req  = req;
    bus.dr_toggle = drPin;
    @(posedge clk);
    cyc++;
    modelStep(req, drPin, cyc);
    #1;
    checkOutput();
    bus.sync_req = 1'b0;
  endtask

  task automatic runCycles(input int n, input int period);
    for (int i = 0; i < n; i++) begin
      if (period > 0 && (i % period) == period - 1) drPin = ~drPin;
      applyStimulus(1'b0);
    end
  endtask

  task automatic toggleEdges(input int n, input int period);
    runCycles(n * period, period);
  endtask

  initial begin
    int p;
    sysRstN = 1'b0;
    bus.sync_req = 1'b0;  bus.dr_toggle = 1'b0;
    bus2.sync_req = 1'b0; bus2.dr_toggle = 1'b0;
    modelReset(1'b1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput();
    sysRstN = 1'b1;

    // Test 1: auto start, toggle every 8 cycles from cycle 40.
    runCycles(39, 0);
    runCycles(LE * 8 + 40, 8);
    checkValue("t1_locked", 32'(bus.locked), 32'd1);
    checkValue("t1_busy", 32'(bus.busy), 32'd0);
    checkValue("t1_retry", 32'(bus.retry_cnt), 32'd0);
    checkValue("t1_sync_rises", 32'(riseCyc.size()), 32'd1);
    checkValue("t1_sync_first_cycle", 32'(riseCyc[0]), 32'd1);

    // Test 3: loss of toggle while locked, then recovery.
    runCycles(100, 0);
    checkValue("t3_locked_dropped", 32'(bus.locked), 32'd0);
    checkValue("t3_retry", 32'(bus.retry_cnt), 32'd1);
    checkValue("t3_state_wait", 32'(bus.state_o), 32'd2);
    p = $urandom_range(12, 4);
    toggleEdges(LE + 40, p);
    checkValue("t3_relocked", 32'(bus.locked), 32'd1);
    checkValue("t3_retry_held", 32'(bus.retry_cnt), 32'd1);

    // Test 5: user resync from LOCKED, request ignored in WAIT_DR.
    applyStimulus(1'b1);
    checkValue("t5_state_sync", 32'(bus.state_o), 32'd1);
    checkValue("t5_locked_low", 32'(bus.locked), 32'd0);
    runCycles(20, 0);
    applyStimulus(1'b1);
    checkValue("t5_ignored_in_wait", 32'(bus.state_o), 32'd2);
    checkValue("t5_retry_cleared", 32'(bus.retry_cnt), 32'd0);

    // Test 4: stall in COUNT, then a full fresh edge count is needed.
    p = $urandom_range(12, 4);
    toggleEdges(100, p);
    runCycles(70, 0);
    checkValue("t4_retry", 32'(bus.retry_cnt), 32'd1);
    checkValue("t4_state_sync", 32'(bus.state_o), 32'd1);
    p = $urandom_range(12, 4);
    toggleEdges(LE + 30, p);
    checkValue("t4_locked", 32'(bus.locked), 32'd1);

    // Test 2: static toggle exhausts retries.
    riseCyc.delete();
    applyStimulus(1'b1);
    runCycles(4 * (SW + TO) + 50, 0);
    checkValue("t2_pulses", 32'(riseCyc.size()), 32'd4);
    if (riseCyc.size() == 4)
      checkValue("t2_spacing", 32'(riseCyc[3] - riseCyc[2]), 32'(SW + TO));
    checkValue("t2_fail", 32'(bus.fail), 32'd1);
    checkValue("t2_state", 32'(bus.state_o), 32'd5);
    checkValue("t2_retry", 32'(bus.retry_cnt), 32'd3);
    applyStimulus(1'b1);
    checkValue("t2_fail_cleared", 32'(bus.fail), 32'd0);
    checkValue("t2_state_sync", 32'(bus.state_o), 32'd1);
    checkValue("t2_retry_cleared", 32'(bus.retry_cnt), 32'd0);

    // Test 6: reset in the middle of a SYNC pulse.
    runCycles(5, 0);
    #3;
    sysRstN = 1'b0;
    #1;
    checkValue("t6_sync_async_low", 32'(bus.sync_o), 32'd0);
    checkValue("t6_state_idle", 32'(bus.state_o), 32'd0);
    modelReset(1'b1);
    prevSync = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    sysRstN = 1'b1;
    runCycles(30, 0);
    checkValue("t6_dut2_idle", 32'(bus2.state_o), 32'd0);
    checkValue("t6_dut2_sync_low", 32'(bus2.sync_o), 32'd0);
    bus2.sync_req = 1'b1;
    applyStimulus(1'b0);
    bus2.sync_req = 1'b0;
    checkValue("t6_dut2_sync_state", 32'(bus2.state_o), 32'd1);
    checkValue("t6_dut2_sync_high", 32'(bus2.sync_o), 32'd1);
    runCycles(SW, 0);
    checkValue("t6_dut2_wait", 32'(bus2.state_o), 32'd2);
    checkValue("t6_dut2_sync_done", 32'(bus2.sync_o), 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
